// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one memory request in flight,
// buffers PC-tagged instruction words in a small FIFO and flushes/restarts on execute redirects.
module fetch_queue_unit #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                     clk,
  input  logic                     n_rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [ILEN-1:0]          imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [ILEN-1:0]          instr_data,
  output logic [XLEN-1:0]          instr_pc,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_valid_q, req_valid_d;
  logic            stale_q, stale_d;
  logic            misalign_q, misalign_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [ILEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q [DEPTH];

  logic            accept_s, push_s, pop_s;
  logic [XLEN-1:0] redir_pc_s;

  // Handshakes; a redirect cancels any push or pop in its cycle.
  always_comb begin
    accept_s   = req_valid_q & imem_req_ready;
    push_s     = (state_q == ST_WAIT) & imem_rsp_valid & ~redirect_valid;
    pop_s      = (count_q != {CW{1'b0}}) & instr_ready & ~redirect_valid;
    redir_pc_s = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // Fetch FSM and PC; a request accepted under (or after) a redirect is stale and gets dropped.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      ST_REQ: begin
        if (accept_s) begin
          req_pc_d = addr_q;
          if (stale_q | redirect_valid) begin
            state_d = ST_DROP;
          end else begin
            state_d    = ST_WAIT;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_s;
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  // FIFO pointers and occupancy.
  always_comb begin
    if (redirect_valid) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Request outputs: an offered but unaccepted request keeps its address, even across redirects.
  always_comb begin
    if (req_valid_q & ~imem_req_ready) begin
      req_valid_d = 1'b1;
      addr_d      = addr_q;
      stale_d     = stale_q | redirect_valid;
    end else begin
      req_valid_d = (state_d == ST_REQ) && (count_d < FULL_C);
      addr_d      = fetch_pc_d;
      stale_d     = 1'b0;
    end
    misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= {XLEN{1'b0}};
      addr_q      <= RESET_PC;
      req_valid_q <= 1'b0;
      stale_q     <= 1'b0;
      misalign_q  <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      addr_q      <= addr_d;
      req_valid_q <= req_valid_d;
      stale_q     <= stale_d;
      misalign_q  <= misalign_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage, tagged with the PC of the request that produced each word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= {ILEN{1'b0}};
        pc_mem_q[i]   <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      data_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = addr_q;
  assign instr_valid    = (count_q != {CW{1'b0}});
  assign instr_data     = data_mem_q[rd_ptr_q];
  assign instr_pc       = pc_mem_q[rd_ptr_q];
  assign misalign_err   = misalign_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a latency-configurable memory returning addr as data,
// and a decode-side scoreboard of expected PCs checked whenever an instruction is consumed.
module tb_fetch_queue_unit;

  logic        clk;
  logic        n_rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [2:0]  fifo_count;

  int          pass_cnt;
  int          total_cnt;
  logic [31:0] sb [$];
  logic [31:0] acc_q [$];
  int          mem_lat;
  int          lat_cnt;
  logic [31:0] lat_addr;
  logic [31:0] exp_pc;

  fetch_queue_unit dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    else return 32'hBAD0_BAD1;
  endfunction

  // Memory: records accepted addresses, answers with the address after mem_lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    lat_cnt        = 0;
    lat_addr       = 32'h0;
    forever begin
      @(negedge clk);
      if (n_rst && imem_req_valid && imem_req_ready) begin
        acc_q.push_back(imem_addr);
        lat_cnt  = mem_lat;
        lat_addr = imem_addr;
      end
      @(posedge clk);
      #1;
      if (!n_rst) begin
        lat_cnt        = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else if (lat_cnt == 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = lat_addr;
        lat_cnt        = 0;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (lat_cnt > 1) lat_cnt--;
      end
    end
  end

  // Decode side: every consumed instruction must match the next expected PC.
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst && instr_valid && instr_ready && !redirect_valid) begin
        check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          exp_pc = sb.pop_front();
          check("instr_pc", instr_pc, exp_pc);
          check("instr_data", instr_data, exp_pc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    check("flush_count", {29'd0, fifo_count}, 32'd0);
    check("flush_valid", {31'd0, instr_valid}, 32'd0);
    check("misalign", {31'd0, misalign_err}, {31'd0, (pc[1:0] != 2'b00)});
  endtask

  task automatic settle();
    instr_ready = 1'b0;
    for (int i = 0; i < 80 && !(fifo_count == 3'd4 && !imem_req_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("settle_full", {29'd0, fifo_count}, 32'd4);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b0;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    n_rst          = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_lat        = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // Straight-line fetch from reset with a 1-cycle memory.
    for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    n_rst          = 1'b1;
    drain("t1_drain");
    check("t1_acc0", acc_at(0), 32'h0);
    check("t1_acc1", acc_at(1), 32'h4);
    check("t1_acc2", acc_at(2), 32'h8);

    // Back-pressure fills the FIFO, then fetch resumes where it stopped.
    do_redirect(32'h0);
    settle();
    check("t2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("t2_addr", imem_addr, 32'h10);
    acc_q.delete();
    for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
    instr_ready = 1'b1;
    drain("t2_drain");
    check("t2_resume", acc_at(0), 32'h10);

    // Redirect while waiting on a slow response: the 0x8 word must never reach decode.
    settle();
    mem_lat = 3;
    acc_q.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    instr_ready = 1'b1;
    do_redirect(32'h0);
    for (int i = 0; i < 60 && acc_q.size() < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("t3_acc8", acc_at(2), 32'h8);
    check("t3_consumed", 32'(sb.size()), 32'd0);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    do_redirect(32'h100);
    drain("t3_drain");
    check("t3_new_addr", acc_at(3), 32'h100);
    mem_lat = 1;

    // Redirect in the same cycle as the response arrives.
    settle();
    acc_q.delete();
    do_redirect(32'h280);
    for (int i = 0; i < 10 && acc_q.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    sb.push_back(32'h300);
    sb.push_back(32'h304);
    instr_ready = 1'b1;
    do_redirect(32'h300);
    drain("t3b_drain");
    check("t3b_acc", acc_at(1), 32'h300);

    // Stalled request holds its address across a redirect, then is dropped.
    settle();
    imem_req_ready = 1'b0;
    acc_q.delete();
    do_redirect(32'h500);
    check("t4_c1_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t4_c1_addr", imem_addr, 32'h500);
    @(posedge clk);
    #1;
    do_redirect(32'h40);
    check("t4_c2_addr", imem_addr, 32'h500);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      check("t4_hold_addr", imem_addr, 32'h500);
    end
    sb.push_back(32'h40);
    sb.push_back(32'h44);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    drain("t4_drain");
    check("t4_acc0", acc_at(0), 32'h500);
    check("t4_acc1", acc_at(1), 32'h40);
    check("t4_acc2", acc_at(2), 32'h44);

    // Misaligned redirect target.
    settle();
    acc_q.delete();
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    do_redirect(32'h203);
    @(posedge clk);
    #1;
    check("t5_misalign_pulse_end", {31'd0, misalign_err}, 32'd0);
    instr_ready = 1'b1;
    drain("t5_drain");
    check("t5_acc0", acc_at(0), 32'h200);

    // PC wrap, then a simultaneous push and pop.
    settle();
    acc_q.delete();
    do_redirect(32'hFFFF_FFFC);
    settle();
    check("t6_acc0", acc_at(0), 32'hFFFF_FFFC);
    check("t6_wrap", acc_at(1), 32'h0);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    for (int i = 0; i < 10 && acc_q.size() < 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("t6_acc4", acc_at(4), 32'hC);
    check("t6_count_pre", {29'd0, fifo_count}, 32'd3);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    check("t6_push_pop_count", {29'd0, fifo_count}, 32'd3);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    sb.push_back(32'hC);
    sb.push_back(32'h10);
    instr_ready = 1'b1;
    drain("t6_drain");

    // Asynchronous reset in the middle of traffic.
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst2_count", {29'd0, fifo_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    instr_ready = 1'b1;
    n_rst       = 1'b1;
    drain("rst2_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
